// File: rtl/day1_vector_packer.sv
// day1_vector_packer: parses an ASCII L/R command stream into 17-bit items and packs LANES items per output vector
module day1_vector_packer #(
  parameter int LANES  = 16,
  parameter int DIST_W = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [7:0]                      s_data,
  input  logic                            s_last,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [LANES*(DIST_W+1)-1:0]     m_flat_data,
  output logic [LANES-1:0]                m_valid_mask,
  output logic                            m_last,
  output logic                            error
`ifdef DAY1_PACKER_STATS_EN
  ,
  output logic [31:0]                     item_count,
  output logic [31:0]                     vector_count
`endif
);
  localparam int ITEM_W = DIST_W + 1;
  localparam int LW     = $clog2(LANES);
  localparam int IW     = LW + 1;
  typedef enum logic {IDLE, DIGITS} state_t;
  state_t                    state_q, state_d;
  logic                      dir_q, dir_d;
  logic [DIST_W-1:0]         acc_q, acc_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [LANES*ITEM_W-1:0]   flat_q, flat_d;
  logic [LANES-1:0]          mask_q, mask_d;
  logic                      mv_q, mv_d;
  logic                      ml_q, ml_d;
  logic                      err_q, err_d;
  logic                      acc_byte, hs;
  logic                      is_eol, is_ws, is_lr, is_dig;
  logic                      go_dig, in_dig, cmp, bad, ovf;
  logic [DIST_W+3:0]         mac;
  logic                      dir_n;
  logic [DIST_W-1:0]         acc_n;
  assign acc_byte = s_valid && s_ready;
  assign hs       = mv_q && m_ready;
  assign is_eol   = s_data == 8'h0A || s_data == 8'h0D;
  assign is_ws    = is_eol || s_data == 8'h20;
  assign is_lr    = s_data == 8'h4C || s_data == 8'h52;
  assign is_dig   = s_data >= 8'h30 && s_data <= 8'h39;
  assign go_dig   = state_q == IDLE && is_lr;
  assign in_dig   = state_q == DIGITS;
  assign mac      = (DIST_W+4)'({acc_q, 3'b000}) + (DIST_W+4)'({acc_q, 1'b0}) + (DIST_W+4)'(s_data[3:0]);
  assign ovf      = |mac[DIST_W+3:DIST_W];
  assign dir_n    = go_dig ? s_data == 8'h52 : dir_q;
  assign acc_n    = go_dig ? '0 : (in_dig && is_dig) ? (ovf ? '1 : mac[DIST_W-1:0]) : acc_q;
  assign cmp      = acc_byte && ((in_dig && is_eol) || (s_last && (go_dig || in_dig)));
  assign bad      = acc_byte && (state_q == IDLE ? !is_lr && !is_ws : (is_dig ? ovf : !is_eol));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  always_comb begin
    state_d = !acc_byte ? state_q : (cmp || s_last) ? IDLE : go_dig ? DIGITS : state_q;
  end
  always_comb begin
    dir_d  = acc_byte ? dir_n : dir_q;
    acc_d  = acc_byte ? acc_n : acc_q;
    idx_d  = idx_q;
    flat_d = flat_q;
    mask_d = mask_q;
    mv_d   = mv_q;
    ml_d   = ml_q;
    err_d  = err_q | bad;
    if (hs) begin
      idx_d  = '0;
      flat_d = '0;
      mask_d = '0;
      mv_d   = 1'b0;
      ml_d   = 1'b0;
    end
    if (cmp) begin
      flat_d[idx_q[LW-1:0]*ITEM_W +: ITEM_W] = {dir_n, acc_n};
      mask_d[idx_q[LW-1:0]]                  = 1'b1;
      idx_d                                  = idx_q + IW'(1);
      mv_d                                   = mv_d | (idx_q == IW'(LANES-1));
    end
    if (acc_byte && s_last) begin
      mv_d = 1'b1;
      ml_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      dir_q  <= 1'b0;
      acc_q  <= '0;
      idx_q  <= '0;
      flat_q <= '0;
      mask_q <= '0;
      mv_q   <= 1'b0;
      ml_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      dir_q  <= dir_d;
      acc_q  <= acc_d;
      idx_q  <= idx_d;
      flat_q <= flat_d;
      mask_q <= mask_d;
      mv_q   <= mv_d;
      ml_q   <= ml_d;
      err_q  <= err_d;
    end
  assign s_ready      = !mv_q;
  assign m_valid      = mv_q;
  assign m_flat_data  = flat_q;
  assign m_valid_mask = mask_q;
  assign m_last       = ml_q;
  assign error        = err_q;
`ifdef DAY1_PACKER_STATS_EN
  logic [31:0] ic_q, vc_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ic_q <= '0;
      vc_q <= '0;
    end else begin
      ic_q <= ic_q + 32'(cmp);
      vc_q <= vc_q + 32'(hs);
    end
  assign item_count   = ic_q;
  assign vector_count = vc_q;
`endif
endmodule
